wb_write_queue: RTL and testbench

- Initiator side of the register-file write port: accepts writeback results from the MEM-result and ALU-result producers and sequences them into the register file's single write port (write_signal / write_add / write_data).
- Buffers up to DEPTH pending writes, so a multi-cycle memory return and an ALU result in the same cycle never collide.
- Provides bypass lookups on both read addresses, so decode sees pending values before they land in the register file.

---
 rtl/wb_write_queue_pkg.sv | 12 +
 rtl/wbq_bypass_match.sv | 42 ++++
 rtl/wb_write_queue.sv | 146 ++++++++++++++
 tb/tb_wb_write_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_write_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_write_queue_pkg
// Brief  : Shared widths for the writeback write queue.
// Rev    : 1.0
// ============================================================================
package wb_write_queue_pkg;
    localparam int WORD_LEN     = 32;
    localparam int REG_ADDR_LEN = 5;
    localparam int WBQ_DEPTH    = 4;
endpackage
`default_nettype wire

// File: rtl/wbq_bypass_match.sv
`default_nettype none
// ============================================================================
// Module : wbq_bypass_match
// Brief  : Youngest-first bypass search over queued writes and the output reg.
// Rev    : 1.0
// ============================================================================
import wb_write_queue_pkg::*;

module wbq_bypass_match #(
    parameter int DEPTH = WBQ_DEPTH
) (
    input  logic [REG_ADDR_LEN-1:0]             rd_add,
    input  logic [DEPTH-1:0]                    ent_valid,
    input  logic [DEPTH-1:0][REG_ADDR_LEN-1:0]  ent_add,
    input  logic [DEPTH-1:0][WORD_LEN-1:0]      ent_data,
    input  logic                                out_valid,
    input  logic [REG_ADDR_LEN-1:0]             out_add,
    input  logic [WORD_LEN-1:0]                 out_data,
    output logic                                hit,
    output logic [WORD_LEN-1:0]                 byp
);

    // Entries are ordered oldest (0) to youngest; later matches override earlier.
    always_comb begin
        hit = 1'b0;
        byp = '0;
        if (rd_add != '0) begin
            if (out_valid && (out_add == rd_add)) begin
                hit = 1'b1;
                byp = out_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid[i] && (ent_add[i] == rd_add)) begin
                    hit = 1'b1;
                    byp = ent_data[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module : wb_write_queue
// Brief  : Merges MEM/ALU writeback results into the single regfile write port.
// Rev    : 1.0
// ============================================================================
import wb_write_queue_pkg::*;

module wb_write_queue #(
    parameter int DEPTH = WBQ_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mem_valid,
    input  logic [REG_ADDR_LEN-1:0]     mem_dest,
    input  logic [WORD_LEN-1:0]         mem_data,
    input  logic                        alu_valid,
    input  logic [REG_ADDR_LEN-1:0]     alu_dest,
    input  logic [WORD_LEN-1:0]         alu_data,
    output logic                        in_ready,
    output logic                        wr_en,
    output logic [REG_ADDR_LEN-1:0]     wr_add,
    output logic [WORD_LEN-1:0]         wr_data,
    input  logic [REG_ADDR_LEN-1:0]     r1_add,
    input  logic [REG_ADDR_LEN-1:0]     r2_add,
    output logic                        r1_hit,
    output logic                        r2_hit,
    output logic [WORD_LEN-1:0]         r1_byp,
    output logic [WORD_LEN-1:0]         r2_byp,
    output logic [$clog2(DEPTH):0]      pending,
    output logic                        idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][REG_ADDR_LEN-1:0] ent_add_q, ent_add_d;
    logic [DEPTH-1:0][WORD_LEN-1:0]     ent_data_q, ent_data_d;
    logic [PTR_W-1:0]                   head_q, head_d;
    logic [PTR_W-1:0]                   tail_q, tail_d;
    logic [CNT_W-1:0]                   count_q, count_d;
    logic                               wr_en_q, wr_en_d;
    logic [REG_ADDR_LEN-1:0]            wr_add_q, wr_add_d;
    logic [WORD_LEN-1:0]                wr_data_q, wr_data_d;

    logic                               mem_en;
    logic                               alu_en;
    logic                               deq;
    logic [PTR_W-1:0]                   alu_slot;

    assign in_ready = (count_q <= CNT_W'(DEPTH - 2));
    // Register 0 is hardwired; writes to it never take a slot.
    assign mem_en   = mem_valid && in_ready && (mem_dest != '0);
    assign alu_en   = alu_valid && in_ready && (alu_dest != '0);
    assign deq      = (count_q != '0);
    assign alu_slot = tail_q + PTR_W'(mem_en);

    always_comb begin
        ent_add_d  = ent_add_q;
        ent_data_d = ent_data_q;
        head_d     = head_q;
        tail_d     = tail_q + PTR_W'(mem_en) + PTR_W'(alu_en);
        count_d    = count_q + CNT_W'(mem_en) + CNT_W'(alu_en) - CNT_W'(deq);
        wr_en_d    = deq;
        wr_add_d   = wr_add_q;
        wr_data_d  = wr_data_q;
        if (mem_en) begin
            ent_add_d[tail_q]  = mem_dest;
            ent_data_d[tail_q] = mem_data;
        end
        if (alu_en) begin
            ent_add_d[alu_slot]  = alu_dest;
            ent_data_d[alu_slot] = alu_data;
        end
        if (deq) begin
            wr_add_d  = ent_add_q[head_q];
            wr_data_d = ent_data_q[head_q];
            head_d    = head_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_add_q  <= '0;
            ent_data_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_add_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            ent_add_q  <= ent_add_d;
            ent_data_q <= ent_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            wr_en_q    <= wr_en_d;
            wr_add_q   <= wr_add_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_add  = wr_add_q;
    assign wr_data = wr_data_q;
    assign pending = count_q;
    assign idle    = (count_q == '0) && !wr_en_q;

    // Age-ordered view of the ring so the matcher needs no pointer arithmetic.
    logic [DEPTH-1:0]                   ord_valid;
    logic [DEPTH-1:0][REG_ADDR_LEN-1:0] ord_add;
    logic [DEPTH-1:0][WORD_LEN-1:0]     ord_data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_order
        assign ord_valid[i] = (CNT_W'(i) < count_q);
        assign ord_add[i]   = ent_add_q[head_q + PTR_W'(i)];
        assign ord_data[i]  = ent_data_q[head_q + PTR_W'(i)];
    end

    wbq_bypass_match #(.DEPTH(DEPTH)) u_byp_r1 (
        .rd_add    (r1_add),
        .ent_valid (ord_valid),
        .ent_add   (ord_add),
        .ent_data  (ord_data),
        .out_valid (wr_en_q),
        .out_add   (wr_add_q),
        .out_data  (wr_data_q),
        .hit       (r1_hit),
        .byp       (r1_byp)
    );

    wbq_bypass_match #(.DEPTH(DEPTH)) u_byp_r2 (
        .rd_add    (r2_add),
        .ent_valid (ord_valid),
        .ent_add   (ord_add),
        .ent_data  (ord_data),
        .out_valid (wr_en_q),
        .out_add   (wr_add_q),
        .out_data  (wr_data_q),
        .hit       (r2_hit),
        .byp       (r2_byp)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_write_queue
// Brief  : Directed vector table plus multi-cycle sequences for wb_write_queue.
// Rev    : 1.0
// ============================================================================
module tb_wb_write_queue;

    logic        clk;
    logic        rst_n;
    logic        mem_valid, alu_valid;
    logic [4:0]  mem_dest, alu_dest;
    logic [31:0] mem_data, alu_data;
    logic        in_ready, wr_en;
    logic [4:0]  wr_add;
    logic [31:0] wr_data;
    logic [4:0]  r1_add, r2_add;
    logic        r1_hit, r2_hit;
    logic [31:0] r1_byp, r2_byp;
    logic [2:0]  pending;
    logic        idle;

    int total = 0;
    int bad   = 0;

    wb_write_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_dest  (mem_dest),
        .mem_data  (mem_data),
        .alu_valid (alu_valid),
        .alu_dest  (alu_dest),
        .alu_data  (alu_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_add    (wr_add),
        .wr_data   (wr_data),
        .r1_add    (r1_add),
        .r2_add    (r2_add),
        .r1_hit    (r1_hit),
        .r2_hit    (r2_hit),
        .r1_byp    (r1_byp),
        .r2_byp    (r2_byp),
        .pending   (pending),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Register-file model commits on the negedge; scoreboard checks write order.
    logic [31:0] rf [32];
    logic [36:0] exp_q [$];
    logic        sb_on = 1'b0;

    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            rf[wr_add] = wr_data;
            if (sb_on) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra actual=%h_%h required=none", wr_add, wr_data);
                end else if ({wr_add, wr_data} !== exp_q[0]) begin
                    bad++;
                    $display("FAIL sb_order actual=%h required=%h", {wr_add, wr_data}, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && !in_ready && (mem_valid || alu_valid)) begin
            bad++;
            $display("FAIL protocol actual=valid_while_not_ready required=no_valid");
        end
    end

    typedef struct {
        logic mv; logic [4:0] md; logic [31:0] mdat;
        logic av; logic [4:0] ad; logic [31:0] adat;
        logic [4:0] r1; logic [4:0] r2;
        logic wen; logic [4:0] wadd; logic [31:0] wdat;
        logic h1; logic [31:0] b1; logic h2; logic [31:0] b2;
        logic [2:0] pend; logic rdy; logic idl;
    } vec_t;

    function automatic vec_t v(
        input logic mv, input logic [4:0] md, input logic [31:0] mdat,
        input logic av, input logic [4:0] ad, input logic [31:0] adat,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic wen, input logic [4:0] wadd, input logic [31:0] wdat,
        input logic h1, input logic [31:0] b1, input logic h2, input logic [31:0] b2,
        input logic [2:0] pend, input logic rdy, input logic idl);
        vec_t t;
        t.mv = mv; t.md = md; t.mdat = mdat; t.av = av; t.ad = ad; t.adat = adat;
        t.r1 = r1; t.r2 = r2; t.wen = wen; t.wadd = wadd; t.wdat = wdat;
        t.h1 = h1; t.b1 = b1; t.h2 = h2; t.b2 = b2;
        t.pend = pend; t.rdy = rdy; t.idl = idl;
        return t;
    endfunction

    task automatic drive(input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                         input logic av, input logic [4:0] ad, input logic [31:0] adat);
        mem_valid = mv; mem_dest = md; mem_data = mdat;
        alu_valid = av; alu_dest = ad; alu_data = adat;
    endtask

    vec_t vecs [18];

    initial begin
        logic [4:0]  d0, d1;
        logic [31:0] x0, x1;
        logic        found;

        // Each row: inputs applied this cycle, outputs expected before the next posedge.
        vecs[0]  = v(0,0,0,           0,0,0,           0,0,   0,0,0,            0,0,            0,0,     0,1,1);
        vecs[1]  = v(0,0,0,           1,5,32'hDEADBEEF, 5,0,  0,0,0,            0,0,            0,0,     0,1,1);
        vecs[2]  = v(0,0,0,           0,0,0,           5,0,   0,0,0,            1,32'hDEADBEEF, 0,0,     1,1,0);
        vecs[3]  = v(0,0,0,           0,0,0,           5,0,   1,5,32'hDEADBEEF, 1,32'hDEADBEEF, 0,0,     0,1,0);
        vecs[4]  = v(1,3,32'h11,      1,3,32'h22,      3,5,   0,5,32'hDEADBEEF, 0,0,            0,0,     0,1,1);
        vecs[5]  = v(0,0,0,           0,0,0,           3,0,   0,5,32'hDEADBEEF, 1,32'h22,       0,0,     2,1,0);
        vecs[6]  = v(0,0,0,           0,0,0,           3,0,   1,3,32'h11,       1,32'h22,       0,0,     1,1,0);
        vecs[7]  = v(0,0,0,           0,0,0,           3,0,   1,3,32'h22,       1,32'h22,       0,0,     0,1,0);
        vecs[8]  = v(1,0,32'hFFFFFFFF, 1,0,32'hFFFFFFFF, 3,0, 0,3,32'h22,       0,0,            0,0,     0,1,1);
        vecs[9]  = v(0,0,0,           0,0,0,           0,0,   0,3,32'h22,       0,0,            0,0,     0,1,1);
        vecs[10] = v(1,7,32'hA7,      0,0,0,           7,0,   0,3,32'h22,       0,0,            0,0,     0,1,1);
        vecs[11] = v(1,8,32'hB8,      1,9,32'hC9,      7,9,   0,3,32'h22,       1,32'hA7,       0,0,     1,1,0);
        vecs[12] = v(1,10,32'hDA,     1,11,32'hEB,     7,9,   1,7,32'hA7,       1,32'hA7,       1,32'hC9, 2,1,0);
        vecs[13] = v(0,0,0,           0,0,0,           8,11,  1,8,32'hB8,       1,32'hB8,       1,32'hEB, 3,0,0);
        vecs[14] = v(0,0,0,           0,0,0,           9,10,  1,9,32'hC9,       1,32'hC9,       1,32'hDA, 2,1,0);
        vecs[15] = v(0,0,0,           0,0,0,           10,11, 1,10,32'hDA,      1,32'hDA,       1,32'hEB, 1,1,0);
        vecs[16] = v(0,0,0,           0,0,0,           11,0,  1,11,32'hEB,      1,32'hEB,       0,0,     0,1,0);
        vecs[17] = v(0,0,0,           0,0,0,           11,0,  0,11,32'hEB,      0,0,            0,0,     0,1,1);

        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        r1_add = '0; r2_add = '0;
        #12;
        chk("rst_wen", wr_en, 0);
        chk("rst_idle", idle, 1);
        chk("rst_pending", pending, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].mv, vecs[i].md, vecs[i].mdat, vecs[i].av, vecs[i].ad, vecs[i].adat);
            r1_add = vecs[i].r1; r2_add = vecs[i].r2;
            #1;
            chk($sformatf("v%0d_wen", i),    wr_en,    vecs[i].wen);
            chk($sformatf("v%0d_wadd", i),   wr_add,   vecs[i].wadd);
            chk($sformatf("v%0d_wdat", i),   wr_data,  vecs[i].wdat);
            chk($sformatf("v%0d_h1", i),     r1_hit,   vecs[i].h1);
            chk($sformatf("v%0d_b1", i),     r1_byp,   vecs[i].b1);
            chk($sformatf("v%0d_h2", i),     r2_hit,   vecs[i].h2);
            chk($sformatf("v%0d_b2", i),     r2_byp,   vecs[i].b2);
            chk($sformatf("v%0d_pend", i),   pending,  vecs[i].pend);
            chk($sformatf("v%0d_rdy", i),    in_ready, vecs[i].rdy);
            chk($sformatf("v%0d_idle", i),   idle,     vecs[i].idl);
        end
        chk("rf_reg5", rf[5], 32'hDEADBEEF);
        chk("rf_reg3", rf[3], 32'h22);
        chk("rf_reg0", rf[0], 32'h0);

        // Pointer wrap: ten single writes.
        sb_on = 1'b1;
        r1_add = '0; r2_add = '0;
        for (int d = 1; d <= 10; d++) begin
            @(negedge clk);
            drive(0, 0, 0, 1, 5'(d), 32'(d) * 32'h100);
            exp_q.push_back({5'(d), 32'(d) * 32'h100});
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            #1;
            if (wr_en && wr_add == 5'd10) found = 1'b1;
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL wrap_timeout actual=no_write required=write_to_r10");
        end else begin
            chk("wrap_rf10", rf[10], 32'hA00);
            @(negedge clk);
            #1;
            chk("wrap_idle", idle, 1);
            chk("wrap_wen_off", wr_en, 0);
        end
        chk("wrap_sb_empty", exp_q.size(), 0);

        // Sustained dual-valid traffic.
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            chk("dual_pend_max", (pending <= 3'd4), 1);
            chk("dual_rdy", in_ready, (pending <= 3'd2));
            if (in_ready) begin
                d0 = 5'($urandom_range(31, 1)); x0 = $urandom;
                d1 = 5'($urandom_range(31, 1)); x1 = $urandom;
                drive(1, d0, x0, 1, d1, x1);
                exp_q.push_back({d0, x0});
                exp_q.push_back({d1, x1});
            end else begin
                drive(0, 0, 0, 0, 0, 0);
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            #1;
            if (idle) found = 1'b1;
        end
        chk("dual_drained", found, 1);
        chk("dual_sb_empty", exp_q.size(), 0);
        sb_on = 1'b0;

        // Asynchronous reset with three entries queued.
        @(negedge clk);
        drive(1, 5'd1, 32'h101, 1, 5'd2, 32'h202);
        @(negedge clk);
        drive(1, 5'd3, 32'h303, 1, 5'd4, 32'h404);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_pend", pending, 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_wen", wr_en, 0);
        chk("arst_pend", pending, 0);
        chk("arst_idle", idle, 1);
        chk("arst_rdy", in_ready, 1);
        chk("arst_wadd", wr_add, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_wen", wr_en, 0);
        chk("post_rst_idle", idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
